// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//
// Decoupled instruction-fetch front end for the RV32IM core. It generates
// sequential fetch addresses, drives a pipelined req/gnt/rvalid instruction bus
// with up to DEPTH requests in flight, buffers returned words in a DEPTH-entry
// prefetch FIFO and hands them to decode over a valid/ready interface.
// A redirect (branch/jump/trap/mret) flushes the FIFO and discards every
// response still in flight for the old stream.
//
// Parameters
//   XLEN     data/address width
//   RSTADDR  first fetch address after reset
//   DEPTH    FIFO entries and max in-flight requests (power of 2, >= 2)
//
// Ports
//   clk_i           clock
//   rstn_i          asynchronous active-low reset
//   instr_req_o     bus request, held with instr_addr_o until grant
//   instr_addr_o    word-aligned fetch address
//   instr_gnt_i     request accepted this cycle
//   instr_rvalid_i  in-order response valid
//   instr_rdata_i   instruction word
//   redirect_i      one-cycle PC change request
//   redirect_pc_i   new PC (bits [1:0] ignored)
//   if_valid_o      instruction available to decode
//   if_ready_i      decode accepts the head instruction
//   if_instr_o      instruction
//   if_pc_o         PC of if_instr_o
//   if_npc_o        if_pc_o + 4
//
// Configuration macro
//   RISCV_FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                          empty and decode is ready is forwarded straight to
//                          the if_* outputs instead of being queued.
// -----------------------------------------------------------------------------
module riscv_fetch_unit #(
   parameter int unsigned     XLEN    = 32,
   parameter logic [XLEN-1:0] RSTADDR = '0,
   parameter int unsigned     DEPTH   = 4
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   output logic            instr_req_o,
   output logic [XLEN-1:0] instr_addr_o,
   input  logic            instr_gnt_i,
   input  logic            instr_rvalid_i,
   input  logic [XLEN-1:0] instr_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_npc_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]   fifo_wptr_q, fifo_wptr_d;
   logic [PW-1:0]   fifo_rptr_q, fifo_rptr_d;
   logic [PW-1:0]   pcq_wptr_q, pcq_wptr_d;
   logic [PW-1:0]   pcq_rptr_q, pcq_rptr_d;

   logic [XLEN-1:0] fifo_instr_mem [DEPTH];
   logic [XLEN-1:0] fifo_pc_mem    [DEPTH];
   // Addresses of granted requests, consumed in order by responses. It is
   // never flushed: stale responses still retire their entry when dropped.
   logic [XLEN-1:0] pcq_mem        [DEPTH];

   logic [CW:0]     credit_used;
   logic            gnt;
   logic            drop_rsp;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            bypass;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] head_instr;
   logic [XLEN-1:0] head_pc;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   // Every request reserves a FIFO slot until its word is popped, so the FIFO
   // can never overflow regardless of bus latency.
   assign credit_used  = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
   assign instr_req_o  = (state_q != ST_BOOT) && (credit_used < DEPTH_W) && !redirect_i;
   assign instr_addr_o = addr_q;
   assign gnt          = instr_req_o & instr_gnt_i;

   assign drop_rsp   = instr_rvalid_i && (drop_q != '0);
   assign rsp_pc     = pcq_mem[pcq_rptr_q];
   assign fifo_empty = (fifo_cnt_q == '0);
   assign head_instr = fifo_empty ? '0 : fifo_instr_mem[fifo_rptr_q];
   assign head_pc    = fifo_empty ? '0 : fifo_pc_mem[fifo_rptr_q];

`ifdef RISCV_FETCH_BYPASS_EN
   assign bypass     = fifo_empty && (drop_q == '0) && instr_rvalid_i && if_ready_i && !redirect_i;
   assign if_valid_o = !fifo_empty || bypass;
   assign if_instr_o = bypass ? instr_rdata_i : head_instr;
   assign if_pc_o    = bypass ? rsp_pc : head_pc;
`else
   assign bypass     = 1'b0;
   assign if_valid_o = !fifo_empty;
   assign if_instr_o = head_instr;
   assign if_pc_o    = head_pc;
`endif

   assign if_npc_o = if_pc_o + XLEN'(4);

   // A redirect overrides both the push of a same-cycle response and any pop.
   assign push = instr_rvalid_i && !drop_rsp && !redirect_i && !bypass;
   assign pop  = !fifo_empty && if_ready_i && !redirect_i;

   always_comb begin
      outst_d     = outst_q + CW'(gnt) - CW'(instr_rvalid_i);
      addr_d      = addr_q;
      drop_d      = drop_q;
      fifo_cnt_d  = fifo_cnt_q;
      fifo_wptr_d = fifo_wptr_q;
      fifo_rptr_d = fifo_rptr_q;
      pcq_wptr_d  = pcq_wptr_q + PW'(gnt);
      pcq_rptr_d  = pcq_rptr_q + PW'(instr_rvalid_i);

      if (redirect_i) begin
         addr_d      = {redirect_pc_i[XLEN-1:2], 2'b00};
         // Everything still outstanding after this cycle belongs to the old stream.
         drop_d      = outst_d;
         fifo_cnt_d  = '0;
         fifo_wptr_d = '0;
         fifo_rptr_d = '0;
      end else begin
         if (gnt) begin
            addr_d = addr_q + XLEN'(4);
         end
         if (drop_rsp) begin
            drop_d = drop_q - CW'(1);
         end
         fifo_wptr_d = fifo_wptr_q + PW'(push);
         fifo_rptr_d = fifo_rptr_q + PW'(pop);
         fifo_cnt_d  = fifo_cnt_q + CW'(push) - CW'(pop);
      end

      case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         default: state_d = (drop_d != '0) ? ST_DRAIN : ST_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= ST_BOOT;
         addr_q      <= RSTADDR;
         outst_q     <= '0;
         drop_q      <= '0;
         fifo_cnt_q  <= '0;
         fifo_wptr_q <= '0;
         fifo_rptr_q <= '0;
         pcq_wptr_q  <= '0;
         pcq_rptr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         outst_q     <= outst_d;
         drop_q      <= drop_d;
         fifo_cnt_q  <= fifo_cnt_d;
         fifo_wptr_q <= fifo_wptr_d;
         fifo_rptr_q <= fifo_rptr_d;
         pcq_wptr_q  <= pcq_wptr_d;
         pcq_rptr_q  <= pcq_rptr_d;
      end
   end

   // Storage arrays carry no reset; the outputs are masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_instr_mem[fifo_wptr_q] <= instr_rdata_i;
         fifo_pc_mem[fifo_wptr_q]    <= rsp_pc;
      end
      if (gnt) begin
         pcq_mem[pcq_wptr_q] <= addr_q;
      end
   end

endmodule
